// File: rtl/bus_timer_if.sv
// Data-bus link between the core's dbus initiator and a memory-mapped responder.
// Request fields are valid while req is high; resp/fault/rdata arrive one cycle later.
interface bus_timer_if;
  logic [31:0] addr;
  logic        w_rb;
  logic [1:0]  acc;
  logic [31:0] wdata;
  logic        req;
  logic [31:0] rdata;
  logic        resp;
  logic        fault;

  modport master (output addr, w_rb, acc, wdata, req,
                  input  rdata, resp, fault);

  modport slave  (input  addr, w_rb, acc, wdata, req,
                  output rdata, resp, fault);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit prescaled up-counter with compare match, level interrupt,
// and a one-cycle registered bus response that also flags malformed accesses.
module bus_timer #(
  parameter int PRE_W = 16,
  parameter int OFS_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  bus_timer_if.slave   bus,
  output logic         tmr_int
);

  typedef enum logic [2:0] {
    REG_CTRL = 3'd0,
    REG_STAT = 3'd1,
    REG_CNT  = 3'd2,
    REG_CMP  = 3'd3,
    REG_PRE  = 3'd4
  } regSel_e;

  logic [2:0]       ctrl_q, ctrl_d;
  logic             pend_q, pend_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      cmp_q, cmp_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] pcnt_q, pcnt_d;
  logic             resp_q, resp_d;
  logic             fault_q, fault_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [OFS_W-1:0] off;
  regSel_e          regSel;
  logic [3:0]       byteEn;
  logic [31:0]      wMask;
  logic             misaligned;
  logic             badOfs;
  logic             fault;
  logic             wrEn;
  logic             rdEn;
  logic [31:0]      readWord;
  logic             tick;
  logic             match;
  logic             unusedAddrBits;

  assign unusedAddrBits = ^bus.addr[31:OFS_W];

  always_comb begin
    off        = bus.addr[OFS_W-1:0];
    regSel     = regSel_e'(off[4:2]);
    byteEn     = 4'b1111;
    misaligned = 1'b0;
    case (bus.acc)
      2'd0: byteEn = 4'b0001 << off[1:0];
      2'd1: begin
        byteEn     = off[1] ? 4'b1100 : 4'b0011;
        misaligned = off[0];
      end
      2'd2: misaligned = (off[1:0] != 2'b00);
      default: byteEn = 4'b1111;
    endcase
    badOfs = (32'(off) > 32'h13);
    fault  = bus.req & ((bus.acc == 2'd3) | misaligned | badOfs);
    wrEn   = bus.req & ~fault & bus.w_rb;
    rdEn   = bus.req & ~fault & ~bus.w_rb;
    wMask  = {{8{byteEn[3]}}, {8{byteEn[2]}}, {8{byteEn[1]}}, {8{byteEn[0]}}};

    case (regSel)
      REG_CTRL: readWord = {29'd0, ctrl_q};
      REG_STAT: readWord = {31'd0, pend_q};
      REG_CNT:  readWord = cnt_q;
      REG_CMP:  readWord = cmp_q;
      REG_PRE:  readWord = 32'(pre_q);
      default:  readWord = 32'd0;
    endcase
  end

  // Prescaler runs only while enabled; lowering PRE below pcnt lets it wrap naturally.
  always_comb begin
    tick   = 1'b0;
    pcnt_d = '0;
    if (ctrl_q[0]) begin
      if (pcnt_q == pre_q) begin
        tick = 1'b1;
      end else begin
        pcnt_d = pcnt_q + PRE_W'(1);
      end
    end
    match = tick & (cnt_q == cmp_q);
  end

  // Timer update first, then bus writes override it; a match always wins on PEND.
  always_comb begin
    ctrl_d = ctrl_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    cmp_d  = cmp_q;
    pre_d  = pre_q;
    if (tick) begin
      if (match) begin
        if (ctrl_q[1]) cnt_d = 32'd0;
        else           ctrl_d[0] = 1'b0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
    if (wrEn) begin
      case (regSel)
        REG_CTRL: ctrl_d = (ctrl_q & ~wMask[2:0]) | (bus.wdata[2:0] & wMask[2:0]);
        REG_STAT: if (byteEn[0] && bus.wdata[0]) pend_d = 1'b0;
        REG_CNT:  cnt_d  = (cnt_q & ~wMask) | (bus.wdata & wMask);
        REG_CMP:  cmp_d  = (cmp_q & ~wMask) | (bus.wdata & wMask);
        REG_PRE:  pre_d  = (pre_q & ~wMask[PRE_W-1:0]) |
                           (bus.wdata[PRE_W-1:0] & wMask[PRE_W-1:0]);
        default: ;
      endcase
    end
    if (match) pend_d = 1'b1;

    resp_d  = bus.req;
    fault_d = fault;
    rdata_d = rdEn ? readWord : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= 3'd0;
      pend_q  <= 1'b0;
      cnt_q   <= 32'd0;
      cmp_q   <= 32'hFFFF_FFFF;
      pre_q   <= '0;
      pcnt_q  <= '0;
      resp_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ctrl_q  <= ctrl_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      pre_q   <= pre_d;
      pcnt_q  <= pcnt_d;
      resp_q  <= resp_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.resp  = resp_q;
  assign bus.fault = fault_q;
  assign bus.rdata = rdata_q;
  assign tmr_int   = pend_q & ctrl_q[2];

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: a register/fault vector table plus cycle-exact
// sequences for periodic match, W1C/match and CNT-write/match collisions, one-shot and reset.
module tb_bus_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tmrInt;
  int   compared = 0;
  int   mismatched = 0;

  bus_timer_if bus ();

  bus_timer #(.PRE_W(16), .OFS_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .tmr_int (tmrInt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [1:0]  acc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expFault;
  } vec_t;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expInt;
  } step_t;

  vec_t  vecs[$];
  step_t steps[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one request before a rising edge and return just after it, when the response is visible.
  task automatic applyStimulus(input logic w, input logic [1:0] acc,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.req   = 1'b1;
    bus.w_rb  = w;
    bus.acc   = acc;
    bus.addr  = addr;
    bus.wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.req = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] wdata);
    applyStimulus(1'b1, 2'd2, addr, wdata);
  endtask

  task automatic readCheck(input string name, input logic [31:0] addr,
                           input logic [31:0] expected);
    applyStimulus(1'b0, 2'd2, addr, 32'd0);
    checkOutput({name, " resp"}, 32'(bus.resp), 32'd1);
    checkOutput({name, " rdata"}, bus.rdata, expected);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req = 1'b0; bus.w_rb = 1'b0; bus.acc = 2'd0; bus.addr = 32'd0; bus.wdata = 32'd0;

    // Register decode, lane merging and fault vectors, timer disabled throughout.
    vecs.push_back('{1'b0, 2'd2, 32'h00,  32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'd2, 32'h04,  32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'd2, 32'h08,  32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'd2, 32'h0C,  32'h0,        32'hFFFFFFFF, 1'b0});
    vecs.push_back('{1'b0, 2'd2, 32'h10,  32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b1, 2'd0, 32'h09,  32'h0000AB00, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 2'd1, 32'h0A,  32'h12340000, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'd2, 32'h08,  32'h0,        32'h1234AB00, 1'b0});
    vecs.push_back('{1'b0, 2'd2, 32'h06,  32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 2'd1, 32'h0D,  32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 2'd3, 32'h00,  32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 2'd2, 32'h14,  32'hFFFFFFFF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 2'd2, 32'h02,  32'h00000007, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 2'd3, 32'h08,  32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 2'd2, 32'h08,  32'h0,        32'h1234AB00, 1'b0});
    vecs.push_back('{1'b0, 2'd2, 32'h00,  32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b1, 2'd2, 32'h0C,  32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'd0, 32'h0F,  32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 2'd1, 32'h10E, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 2'd2, 32'h10,  32'hFFFF1234, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'd2, 32'h10,  32'h0,        32'h00001234, 1'b0});
    vecs.push_back('{1'b1, 2'd1, 32'h12,  32'hFFFF0000, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'd2, 32'h10,  32'h0,        32'h00001234, 1'b0});
    vecs.push_back('{1'b1, 2'd2, 32'h00,  32'hFFFFFFF8, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'd2, 32'h00,  32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b1, 2'd0, 32'h0C,  32'h00000077, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'd2, 32'h0C,  32'h0,        32'hDEADBE77, 1'b0});
    vecs.push_back('{1'b0, 2'd0, 32'h13,  32'h0,        32'h00001234, 1'b0});
    vecs.push_back('{1'b0, 2'd0, 32'h14,  32'h0,        32'h0,        1'b1});

    // One access per cycle after CTRL=7 with CMP=3, PRE=1: CNT moves every 2 cycles, matches every 8.
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h0,  1'b0});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h0,  1'b0});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h1,  1'b0});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h1,  1'b0});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h2,  1'b0});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h2,  1'b0});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h3,  1'b0});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h3,  1'b1});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h0,  1'b1});
    steps.push_back('{1'b1, 32'h04, 32'h1,  32'h0,  1'b0});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h1,  1'b0});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h1,  1'b0});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h2,  1'b0});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h2,  1'b0});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h3,  1'b0});
    steps.push_back('{1'b1, 32'h04, 32'h1,  32'h0,  1'b1});
    steps.push_back('{1'b0, 32'h04, 32'h0,  32'h1,  1'b1});
    steps.push_back('{1'b1, 32'h04, 32'h1,  32'h0,  1'b0});
    steps.push_back('{1'b0, 32'h04, 32'h0,  32'h0,  1'b0});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h1,  1'b0});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h2,  1'b0});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h2,  1'b0});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h3,  1'b0});
    steps.push_back('{1'b1, 32'h08, 32'h10, 32'h0,  1'b1});
    steps.push_back('{1'b0, 32'h08, 32'h0,  32'h10, 1'b1});
    steps.push_back('{1'b0, 32'h04, 32'h0,  32'h1,  1'b1});
    steps.push_back('{1'b1, 32'h00, 32'h0,  32'h0,  1'b0});

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset resp", 32'(bus.resp), 32'd0);
    checkOutput("reset fault", 32'(bus.fault), 32'd0);
    checkOutput("reset rdata", bus.rdata, 32'd0);
    checkOutput("reset tmr_int", 32'(tmrInt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].w, vecs[i].acc, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d resp", i), 32'(bus.resp), 32'd1);
      checkOutput($sformatf("vec%0d fault", i), 32'(bus.fault), 32'(vecs[i].expFault));
      if (!vecs[i].w || vecs[i].expFault)
        checkOutput($sformatf("vec%0d rdata", i), bus.rdata, vecs[i].expRdata);
    end
    idle(1);
    checkOutput("idle resp", 32'(bus.resp), 32'd0);
    checkOutput("idle rdata", bus.rdata, 32'd0);

    writeReg(32'h0C, 32'd3);
    writeReg(32'h10, 32'd1);
    writeReg(32'h08, 32'd0);
    writeReg(32'h00, 32'd7);
    foreach (steps[i]) begin
      applyStimulus(steps[i].w, 2'd2, steps[i].addr, steps[i].wdata);
      checkOutput($sformatf("step%0d resp", i), 32'(bus.resp), 32'd1);
      checkOutput($sformatf("step%0d fault", i), 32'(bus.fault), 32'd0);
      if (!steps[i].w)
        checkOutput($sformatf("step%0d rdata", i), bus.rdata, steps[i].expRdata);
      checkOutput($sformatf("step%0d tmr_int", i), 32'(tmrInt), 32'(steps[i].expInt));
    end

    // One-shot: CNT stops on the match and EN self-clears.
    writeReg(32'h04, 32'd1);
    writeReg(32'h08, 32'd0);
    writeReg(32'h10, 32'd0);
    writeReg(32'h0C, 32'd2);
    writeReg(32'h00, 32'd1);
    idle(6);
    readCheck("oneshot cnt", 32'h08, 32'd2);
    readCheck("oneshot ctrl", 32'h00, 32'd0);
    readCheck("oneshot stat", 32'h04, 32'd1);
    checkOutput("oneshot tmr_int", 32'(tmrInt), 32'd0);
    writeReg(32'h00, 32'd4);
    checkOutput("ie tmr_int", 32'(tmrInt), 32'd1);
    writeReg(32'h04, 32'd1);
    checkOutput("w1c tmr_int", 32'(tmrInt), 32'd0);
    readCheck("pre cnt", 32'h08, 32'd2);

    // Reset coincident with a request drops the response and restores every register.
    @(negedge clk);
    bus.req = 1'b1; bus.w_rb = 1'b0; bus.acc = 2'd2; bus.addr = 32'h08;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst resp", 32'(bus.resp), 32'd0);
    checkOutput("midrst rdata", bus.rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req = 1'b0;
    readCheck("postrst cmp", 32'h0C, 32'hFFFFFFFF);
    readCheck("postrst cnt", 32'h08, 32'd0);
    readCheck("postrst ctrl", 32'h00, 32'd0);
    readCheck("postrst pre", 32'h10, 32'd0);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
# bus_timer

Memory-mapped 32-bit timer that sits on the data bus as a responder to the core's `dbus` initiator port. It decodes register accesses, answers every request with a one-cycle registered response, and reports malformed accesses on a fault strobe for fault arbitration. A prescaled up-counter with compare match raises a level interrupt toward the external interrupt controller.

## Interface
- `PRE_W`, 16: prescaler register width (1..32).
- `OFS_W`, 5: address bits decoded; upper address bits are ignored (the top level decodes the base).

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bus_addr`  in  32  byte address; only `[OFS_W-1:0]` is used.
- `bus_w_rb`  in  1  1 = write, 0 = read.
- `bus_acc`  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `bus_wdata`  in  32  write data, lane-aligned to the address.
- `bus_req`  in  1  request strobe; the other request inputs are valid when it is high.
- `bus_rdata`  out  32  read data, valid while `bus_resp` = 1.
- `bus_resp`  out  1  one-cycle response strobe.
- `bus_fault`  out  1  one-cycle fault strobe, coincident with `bus_resp`.
- `tmr_int`  out  1  level interrupt: `PEND & IE`.

## Operation
- Registers (word offsets):
  - 0x00 CTRL: `[0]` EN, `[1]` AUTO, `[2]` IE; other bits read 0.
  - 0x04 STAT: `[0]` PEND. Write-1-to-clear; other bits read 0.
  - 0x08 CNT: 32-bit counter, read/write.
  - 0x0C CMP: 32-bit compare value, read/write.
  - 0x10 PRE: `PRE_W`-bit prescaler reload, zero-extended on read.
- Fault conditions. A fault suppresses the register update and returns `bus_rdata` = 0.
  - `bus_acc` = 3.
  - Misalignment: half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
  - Offset > 0x13.
- Reads return the full aligned 32-bit word regardless of `bus_acc`; the initiator extracts lanes. Reads have no side effects.
- Writes:
  - Byte writes update lane `addr[1:0]`; half writes update lanes `{addr[1],0}` and `{addr[1],1}`; word writes update all lanes.
  - Bits outside a register's width are ignored.
  - A STAT byte write touching lane 0 clears PEND if `wdata[0]` = 1.
- Prescaler `pcnt`:
  - While EN = 1: if `pcnt` == PRE, `pcnt` ← 0 and `tick` = 1; otherwise `pcnt`++.
  - While EN = 0, `pcnt` ← 0.
  - PRE = 0 ticks every cycle.
- Counter, on `tick`:
  - If CNT == CMP (match): PEND ← 1. With AUTO = 1, CNT ← 0. With AUTO = 0, CNT holds and EN ← 0 (one-shot).
  - Otherwise CNT ← CNT + 1 (mod 2^32). Wrap from 0xFFFFFFFF to 0 raises no event.
- Priorities within one cycle:
  - A bus write to CNT, CTRL or PRE overrides the timer's own update of that register, but a match detected in that cycle still sets PEND.
  - A match setting PEND beats a simultaneous W1C of PEND.
  - Writing PRE does not reset `pcnt`. If the new PRE is below `pcnt`, `pcnt` counts up and wraps at 2^PRE_W.

## Timing
- Request in cycle N → `bus_resp` (and `bus_fault`, if applicable) high in cycle N+1 for exactly one cycle. `bus_rdata` is registered and valid in N+1; it is 0 whenever `bus_resp` = 0.
- Back-to-back requests are supported: a request every cycle gets a response every cycle, with no stall.
- A read in cycle N returns register contents as of the start of cycle N, so it does not see a write or tick from the same cycle.
- A write in cycle N is visible to a read issued in N+1.
- A match on the tick in cycle N sets PEND in N+1, and `tmr_int` rises in N+1 (registered PEND, combinational AND with IE).
- Reset values: CTRL = 0, STAT = 0, CNT = 0, CMP = 0xFFFFFFFF, PRE = 0, `pcnt` = 0. Outputs `bus_resp`, `bus_fault`, `tmr_int` = 0 and `bus_rdata` = 0.
- Reset asserted mid-transaction: the pending response is dropped (`bus_resp` = 0 in the following cycle) and all state returns to reset values.

## Test plan
- Reset, then word-read each of 0x00..0x10 → `rdata` = 0, 0, 0, 0xFFFFFFFF, 0 respectively; `bus_resp` one cycle after each `bus_req`; `bus_fault` = 0.
- Write CMP = 3, PRE = 1, CTRL = 0x7 → CNT steps 0, 1, 2, 3 every 2 cycles; on the match PEND = 1, `tmr_int` = 1, CNT → 0; write STAT = 1 → `tmr_int` = 0 the next cycle.
- One-shot: CMP = 2, PRE = 0, CTRL = 0x1 → CNT halts at 2, CTRL reads 0x0, PEND = 1, `tmr_int` = 0 (IE = 0).
- Byte write 0xAB to 0x09, then half write 0x1234 to 0x0A, with CNT = 0 and the timer disabled → CNT reads 0x1234AB00.
- Faults: word read at 0x06, half at 0x0D, `acc` = 3 at 0x00, word write to 0x14 → each gives `bus_resp` = `bus_fault` = 1, `rdata` = 0, no register changes.
- Simultaneous events: W1C of STAT in the same cycle as a match → PEND stays 1; CNT write of 0x10 in the same cycle as a match → CNT = 0x10 and PEND = 1.
